// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-serial memory arbiter.
package mem_pkg;

    localparam int unsigned AW_DEF = 32;
    localparam int unsigned DW_DEF = 32;

    // mm_cu encodings: byte count minus one
    localparam logic [1:0] CU_B = 2'd0;
    localparam logic [1:0] CU_H = 2'd1;
    localparam logic [1:0] CU_W = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StIfRd,
        StMmRd,
        StMmWr,
        StDone
    } state_e;

    // Little-endian byte lane select
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester and RAM-side signal bundle of the memory arbiter.
interface mem_arb_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    // Instruction fetch requester
    logic          if_e;
    logic [AW-1:0] if_a;
    logic [DW-1:0] if_n;
    logic          if_ok;

    // Memory-stage requester
    logic          mm_e;
    logic          mm_wr;
    logic [AW-1:0] mm_a;
    logic [1:0]    mm_cu;
    logic [DW-1:0] mm_n_i;
    logic [DW-1:0] mm_n_o;
    logic          mm_ok;

    // Byte-wide RAM port
    logic [7:0]    ram_rn;
    logic [7:0]    ram_wn;
    logic [AW-1:0] ram_a;
    logic          ram_wr;

    // Core + RAM side
    modport master (
        output if_e, if_a, mm_e, mm_wr, mm_a, mm_cu, mm_n_i, ram_rn,
        input  if_n, if_ok, mm_n_o, mm_ok, ram_wn, ram_a, ram_wr
    );

    // Arbiter side
    modport slave (
        input  if_e, if_a, mm_e, mm_wr, mm_a, mm_cu, mm_n_i, ram_rn,
        output if_n, if_ok, mm_n_o, mm_ok, ram_wn, ram_a, ram_wr
    );

endinterface

// File: rtl/byte_asm.sv
// Little-endian word assembler: collects read bytes one lane at a time.
// 'word' already contains the byte being captured this cycle, so the
// owner can register the complete word on the same edge as the last capture.
module byte_asm #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          cap,
    input  logic [1:0]    idx,
    input  logic [7:0]    din,
    output logic [DW-1:0] word
);

    logic [DW-1:0] word_q;
    logic [DW-1:0] word_d;

    // Merge the incoming byte into its lane
    always_comb begin
        word_d = word_q;
        if (cap) begin
            word_d[{idx, 3'b000} +: 8] = din;
        end
    end

    // Assembly register; cleared while the arbiter is idle so short loads zero-extend
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= '0;
        end else if (clr) begin
            word_q <= '0;
        end else if (cap) begin
            word_q <= word_d;
        end
    end

    assign word = word_d;

endmodule

// File: rtl/mem_arb.sv
// Byte-serial arbiter between instruction fetch / memory stage and an 8-bit RAM.
// Memory stage wins ties; a running transfer is never preempted. All outputs
// are registered, so every *_d below is the value seen in the next cycle.
module mem_arb
    import mem_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input logic      clk,
    input logic      rst,
    mem_arb_if.slave bus
);

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [2:0]    len_q, len_d;
    logic [AW-1:0] base_q, base_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic [DW-1:0] if_n_q, if_n_d;
    logic          if_ok_q, if_ok_d;
    logic [DW-1:0] mm_n_o_q, mm_n_o_d;
    logic          mm_ok_q, mm_ok_d;
    logic [7:0]    ram_wn_q, ram_wn_d;
    logic [AW-1:0] ram_a_q, ram_a_d;
    logic          ram_wr_q, ram_wr_d;

    logic          asm_clr;
    logic          asm_cap;
    logic [1:0]    asm_idx;
    logic [DW-1:0] asm_word;

    // Byte i-1 arrives in busy cycle i; an aborting fetch captures nothing
    assign asm_clr = (state_q == StIdle);
    assign asm_cap = (((state_q == StIfRd) && bus.if_e) || (state_q == StMmRd)) &&
                     (cnt_q != 3'd0);
    assign asm_idx = 2'(cnt_q - 3'd1);

    byte_asm #(
        .DW (DW)
    ) u_byte_asm (
        .clk  (clk),
        .rst  (rst),
        .clr  (asm_clr),
        .cap  (asm_cap),
        .idx  (asm_idx),
        .din  (bus.ram_rn),
        .word (asm_word)
    );

    // Arbitration, byte sequencing and next values of the registered outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        base_d   = base_q;
        wdata_d  = wdata_q;
        if_n_d   = if_n_q;
        mm_n_o_d = mm_n_o_q;
        if_ok_d  = 1'b0;
        mm_ok_d  = 1'b0;
        ram_wn_d = 8'h00;
        ram_a_d  = '0;
        ram_wr_d = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = 3'd0;
                if (bus.mm_e) begin
                    base_d  = bus.mm_a;
                    len_d   = {1'b0, bus.mm_cu} + 3'd1;
                    wdata_d = bus.mm_n_i;
                    ram_a_d = bus.mm_a;
                    if (bus.mm_wr) begin
                        state_d  = StMmWr;
                        ram_wr_d = 1'b1;
                        ram_wn_d = bus.mm_n_i[7:0];
                    end else begin
                        state_d = StMmRd;
                    end
                end else if (bus.if_e) begin
                    base_d  = bus.if_a;
                    len_d   = {1'b0, CU_W} + 3'd1;
                    ram_a_d = bus.if_a;
                    state_d = StIfRd;
                end
            end

            StIfRd, StMmRd: begin
                if ((state_q == StIfRd) && !bus.if_e) begin
                    // Fetch withdrawn: drop partial data, no completion
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == len_q) begin
                        state_d = StDone;
                        if (state_q == StIfRd) begin
                            if_ok_d = 1'b1;
                            if_n_d  = asm_word;
                        end else begin
                            mm_ok_d  = 1'b1;
                            mm_n_o_d = asm_word;
                        end
                    end else if (cnt_q == len_q - 3'd1) begin
                        // Extra cycle waits for the last byte; address stays put
                        ram_a_d = ram_a_q;
                    end else begin
                        ram_a_d = base_q + AW'(cnt_d);
                    end
                end
            end

            StMmWr: begin
                if (cnt_q == len_q - 3'd1) begin
                    state_d = StDone;
                    mm_ok_d = 1'b1;
                end else begin
                    cnt_d    = cnt_q + 3'd1;
                    ram_wr_d = 1'b1;
                    ram_a_d  = base_q + AW'(cnt_d);
                    ram_wn_d = byte_of(wdata_q, cnt_d[1:0]);
                end
            end

            StDone: begin
                // Requests are not sampled here, forcing one idle cycle
                state_d = StIdle;
                cnt_d   = 3'd0;
            end

            default: begin
                state_d = StIdle;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State, transfer context and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            len_q    <= 3'd0;
            base_q   <= '0;
            wdata_q  <= '0;
            if_n_q   <= '0;
            if_ok_q  <= 1'b0;
            mm_n_o_q <= '0;
            mm_ok_q  <= 1'b0;
            ram_wn_q <= 8'h00;
            ram_a_q  <= '0;
            ram_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            base_q   <= base_d;
            wdata_q  <= wdata_d;
            if_n_q   <= if_n_d;
            if_ok_q  <= if_ok_d;
            mm_n_o_q <= mm_n_o_d;
            mm_ok_q  <= mm_ok_d;
            ram_wn_q <= ram_wn_d;
            ram_a_q  <= ram_a_d;
            ram_wr_q <= ram_wr_d;
        end
    end

    assign bus.if_n   = if_n_q;
    assign bus.if_ok  = if_ok_q;
    assign bus.mm_n_o = mm_n_o_q;
    assign bus.mm_ok  = mm_ok_q;
    assign bus.ram_wn = ram_wn_q;
    assign bus.ram_a  = ram_a_q;
    assign bus.ram_wr = ram_wr_q;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: vector table, hand-written corner sequences and random
// transfers checked against a byte-array memory model.
module tb_mem_arb;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arb_if #(.AW(32), .DW(32)) bus ();

    mem_arb #(.AW(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [7:0]  ram     [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] seq_a   [8];
    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          fetch;
        bit          wr;
        logic [31:0] addr;
        logic [1:0]  cu;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [10];

    // RAM: read data appears the cycle after its address; writes on the edge
    always @(posedge clk) begin
        bus.ram_rn <= ram.exists(bus.ram_a) ? ram[bus.ram_a] : 8'h00;
        if (bus.ram_wr === 1'b1) ram[bus.ram_a] = bus.ram_wn;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] w = '0;
        for (int k = 0; k < n; k++) w = w | (32'(ref_rd(a + 32'(k))) << (8 * k));
        return w;
    endfunction

    task automatic model_store(input logic [31:0] a, input int n, input logic [31:0] d);
        for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = 8'(d >> (8 * k));
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        ram[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // One transfer from an idle cycle; checks the per-cycle RAM stream and the idle cycle after
    task automatic run_xfer(input bit fetch, input bit wr, input logic [31:0] addr,
                            input logic [1:0] cu, input logic [31:0] wdata,
                            output logic [31:0] data, output int lat);
        int  n;
        int  k;
        bit  seq_ok;
        bit  done;
        n = fetch ? 4 : int'(cu) + 1;
        if (fetch) begin
            bus.if_e = 1'b1; bus.if_a = addr;
        end else begin
            bus.mm_e = 1'b1; bus.mm_wr = wr; bus.mm_a = addr; bus.mm_cu = cu;
            bus.mm_n_i = wdata;
        end
        lat = 0; seq_ok = 1'b1; done = 1'b0; data = '0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat <= 8) seq_a[lat-1] = bus.ram_a;
            if (bus.if_ok === 1'b1 && bus.mm_ok === 1'b1) seq_ok = 1'b0;
            if (bus.if_ok === 1'b1 || bus.mm_ok === 1'b1) begin
                done = 1'b1;
                if (fetch != (bus.if_ok === 1'b1)) seq_ok = 1'b0;
                data = fetch ? bus.if_n : bus.mm_n_o;
                bus.if_e = 1'b0;
                bus.mm_e = 1'b0;
            end else begin
                k = lat - 1;
                if (!fetch && wr) begin
                    if (k >= n) seq_ok = 1'b0;
                    else if (bus.ram_wr !== 1'b1 || bus.ram_a !== addr + 32'(k) ||
                             bus.ram_wn !== 8'(wdata >> (8 * k))) seq_ok = 1'b0;
                end else begin
                    if (k > n) seq_ok = 1'b0;
                    else if (bus.ram_wr !== 1'b0 ||
                             bus.ram_a !== addr + 32'((k < n) ? k : n - 1)) seq_ok = 1'b0;
                end
            end
        end
        bus.if_e = 1'b0;
        bus.mm_e = 1'b0;
        chk("ram_seq", 64'(seq_ok), 64'd1);
        @(posedge clk); #1;
        chk("idle_after", {bus.ram_wr, bus.if_ok, bus.mm_ok, bus.ram_a}, 64'd0);
    endtask

    logic [31:0] data;
    int          lat;
    logic [31:0] wrap_exp [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    initial begin
        bus.if_e = 1'b0; bus.if_a = '0; bus.mm_e = 1'b0; bus.mm_wr = 1'b0;
        bus.mm_a = '0; bus.mm_cu = '0; bus.mm_n_i = '0;

        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h10); poke(32'h103, 8'h00);
        poke(32'h40, 8'h9A);
        poke(32'h2000, 8'h01); poke(32'h2001, 8'h02); poke(32'h2002, 8'h11); poke(32'h2003, 8'h22);
        poke(32'h200, 8'hAA); poke(32'h201, 8'hBB); poke(32'h202, 8'hCC); poke(32'h203, 8'hDD);
        poke(32'hFFFF_FFFE, 8'h5A); poke(32'hFFFF_FFFF, 8'h6B);
        poke(32'h0, 8'h7C); poke(32'h1, 8'h8D);
        poke(32'h3000, 8'h11); poke(32'h3001, 8'h22); poke(32'h3002, 8'h33); poke(32'h3003, 8'h44);

        //          fetch wr   addr         cu    wdata          exp_data       lat
        vecs[0] = '{1'b1, 1'b0, 32'h100,  CU_W, 32'h0,         32'h0010_0513, 6};
        vecs[1] = '{1'b0, 1'b1, 32'h2000, CU_H, 32'hDEAD_BEEF, 32'h0,         3};
        vecs[2] = '{1'b0, 1'b0, 32'h40,   CU_B, 32'h0,         32'h0000_009A, 3};
        vecs[3] = '{1'b0, 1'b0, 32'h100,  CU_H, 32'h0,         32'h0000_0513, 4};
        vecs[4] = '{1'b0, 1'b0, 32'h2000, CU_W, 32'h0,         32'h2211_BEEF, 6};
        vecs[5] = '{1'b0, 1'b1, 32'h2003, CU_B, 32'h0000_0055, 32'h0,         2};
        vecs[6] = '{1'b0, 1'b0, 32'h2000, CU_W, 32'h0,         32'h5511_BEEF, 6};
        vecs[7] = '{1'b0, 1'b1, 32'h500,  CU_W, 32'h0102_0304, 32'h0,         5};
        vecs[8] = '{1'b1, 1'b0, 32'h500,  CU_W, 32'h0,         32'h0102_0304, 6};
        vecs[9] = '{1'b0, 1'b0, 32'h501,  2'd2, 32'h0,         32'h0001_0203, 5};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ram", {bus.ram_wr, bus.ram_wn, bus.ram_a}, 64'd0);
        chk("reset_if", {bus.if_ok, bus.if_n}, 64'd0);
        chk("reset_mm", {bus.mm_ok, bus.mm_n_o}, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Vector table
        for (int t = 0; t < 10; t++) begin
            run_xfer(vecs[t].fetch, vecs[t].wr, vecs[t].addr, vecs[t].cu, vecs[t].wdata,
                     data, lat);
            chk($sformatf("vec%0d_lat", t), 64'(lat), 64'(vecs[t].exp_lat));
            if (vecs[t].wr) model_store(vecs[t].addr, int'(vecs[t].cu) + 1, vecs[t].wdata);
            else chk($sformatf("vec%0d_data", t), 64'(data), 64'(vecs[t].exp_data));
        end
        chk("store_h_untouched", {ram_rd(32'h2002), ram_rd(32'h2003)}, 64'h1155);

        // Collision: both requesters rise together, memory stage goes first
        begin
            int c = 0, mm_at = -1, if_at = -1;
            logic [31:0] first_a = '0, mm_data = '0, if_data = '0;
            bus.if_e = 1'b1; bus.if_a = 32'h100;
            bus.mm_e = 1'b1; bus.mm_wr = 1'b0; bus.mm_a = 32'h40; bus.mm_cu = CU_B;
            while (if_at < 0 && c < 30) begin
                @(posedge clk); #1;
                c++;
                if (c == 1) first_a = bus.ram_a;
                if (bus.mm_ok === 1'b1) begin mm_at = c; mm_data = bus.mm_n_o; bus.mm_e = 1'b0; end
                if (bus.if_ok === 1'b1) begin if_at = c; if_data = bus.if_n; bus.if_e = 1'b0; end
            end
            bus.if_e = 1'b0; bus.mm_e = 1'b0;
            chk("coll_first_addr", 64'(first_a), 64'h40);
            chk("coll_mm_cycle", 64'(mm_at), 64'd3);
            chk("coll_mm_data", 64'(mm_data), 64'h9A);
            chk("coll_if_cycle", 64'(if_at), 64'd10);
            chk("coll_if_data", 64'(if_data), 64'h0010_0513);
            @(posedge clk); #1;
        end

        // Abort: fetch withdrawn in its second busy cycle
        begin
            bit saw = 1'b0;
            bus.if_e = 1'b1; bus.if_a = 32'h100;
            @(posedge clk); #1;
            @(posedge clk); #1;
            bus.if_e = 1'b0;
            @(posedge clk); #1;
            chk("abort_idle", {bus.ram_wr, bus.ram_a}, 64'd0);
            repeat (8) begin
                if (bus.if_ok !== 1'b0) saw = 1'b1;
                @(posedge clk); #1;
            end
            chk("abort_no_ok", 64'(saw), 64'd0);
            chk("abort_if_n_hold", 64'(bus.if_n), 64'h0010_0513);
            run_xfer(1'b1, 1'b0, 32'h200, CU_W, 32'h0, data, lat);
            chk("refetch_lat", 64'(lat), 64'd6);
            chk("refetch_data", 64'(data), 64'hDDCC_BBAA);
        end

        // Address wrap
        run_xfer(1'b0, 1'b0, 32'hFFFF_FFFE, CU_W, 32'h0, data, lat);
        chk("wrap_data", 64'(data), 64'h8D7C_6B5A);
        for (int k = 0; k < 4; k++) chk($sformatf("wrap_addr%0d", k), 64'(seq_a[k]),
                                        64'(wrap_exp[k]));

        // Reset during a word store, while byte 2 is on the bus
        begin
            bit saw = 1'b0;
            bus.mm_e = 1'b1; bus.mm_wr = 1'b1; bus.mm_a = 32'h3000; bus.mm_cu = CU_W;
            bus.mm_n_i = 32'hA1B2_C3D4;
            repeat (3) begin @(posedge clk); #1; end
            rst = 1'b0;
            #1;
            chk("rst_mid_ram", {bus.ram_wr, bus.ram_wn, bus.ram_a}, 64'd0);
            chk("rst_mid_if", {bus.if_ok, bus.if_n}, 64'd0);
            chk("rst_mid_mm", {bus.mm_ok, bus.mm_n_o}, 64'd0);
            bus.mm_e = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b1;
            repeat (10) begin
                @(posedge clk); #1;
                if (bus.mm_ok !== 1'b0) saw = 1'b1;
            end
            chk("rst_no_ok", 64'(saw), 64'd0);
            chk("rst_partial_bytes", {ram_rd(32'h3000), ram_rd(32'h3001), ram_rd(32'h3002),
                                      ram_rd(32'h3003)}, 64'hD4C3_3344);
            model_store(32'h3000, 2, 32'h0000_C3D4);
        end

        // Random transfers against the memory model
        for (int a = 0; a < 64; a++) poke(32'h1000 + 32'(a), 8'($urandom));
        for (int t = 0; t < 40; t++) begin
            bit          fetch, wr;
            logic [1:0]  cu;
            logic [31:0] addr, wdata, exp;
            int          n;
            fetch = ($urandom_range(0, 3) == 0);
            wr    = fetch ? 1'b0 : 1'($urandom_range(0, 1));
            cu    = fetch ? CU_W : 2'($urandom_range(0, 3));
            addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                : 32'h1000 + 32'($urandom_range(0, 60));
            wdata = $urandom;
            n     = int'(cu) + 1;
            exp   = model_read(addr, n);
            run_xfer(fetch, wr, addr, cu, wdata, data, lat);
            if (wr) begin
                chk($sformatf("rnd%0d_lat", t), 64'(lat), 64'(n + 1));
                model_store(addr, n, wdata);
            end else begin
                chk($sformatf("rnd%0d_lat", t), 64'(lat), 64'(n + 2));
                chk($sformatf("rnd%0d_data", t), 64'(data), 64'(exp));
            end
        end
        begin
            int bad = 0;
            for (int a = 0; a < 68; a++)
                if (ram_rd(32'h1000 + 32'(a)) !== ref_rd(32'h1000 + 32'(a))) bad++;
            for (int a = -4; a < 4; a++)
                if (ram_rd(32'(a)) !== ref_rd(32'(a))) bad++;
            chk("ram_image", 64'(bad), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
